sdram_port_arbiter: RTL and testbench

- Shares the single SDRAM controller between the program-cache fill port (p1: read-only, 64-bit lines) and the data-cache port (p2: line read and line write-back).
- Also schedules periodic auto-refresh.
- Sits between the two cache controllers and the SDRAM controller in PVP.
- Latches each granted request, forwards it downstream, and returns a registered one-cycle ready pulse to the owning port.

---
 rtl/sdram_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one SDRAM controller between the program-cache fill port (p1,
//   read-only) and the data-cache port (p2, read / write-back), and slots in
//   periodic auto-refresh. Each granted request is latched and held on the
//   mem_* side until mem_ready; the owning port then sees a registered
//   one-cycle ready pulse.
// Ports
//   clk, reset (async, active-low)
//   p1_req/p1_address -> p1_data/p1_ready            program line reads
//   p2_req/p2_wren/p2_address/p2_to_mem -> p2_from_mem/p2_ready
//   mem_req/mem_refresh/mem_wren/mem_address/mem_wdata -> controller
//   mem_rdata/mem_ready <- controller
module sdram_port_arbiter #(
    parameter int          REFRESH_INTERVAL = 390,
    parameter logic [13:0] P2_BASE          = 14'h2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p1_req,
    input  logic [13:0] p1_address,
    output logic [63:0] p1_data,
    output logic        p1_ready,
    input  logic        p2_req,
    input  logic        p2_wren,
    input  logic [12:0] p2_address,
    input  logic [63:0] p2_to_mem,
    output logic [63:0] p2_from_mem,
    output logic        p2_ready,
    output logic        mem_req,
    output logic        mem_refresh,
    output logic        mem_wren,
    output logic [13:0] mem_address,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int CW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

    typedef enum logic [2:0] {IDLE, REFRESH, SERVE_P1, SERVE_P2, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          last_p2_q, last_p2_d;   // 1: p2 was granted last
    logic          mem_req_q, mem_req_d;
    logic          mem_refresh_q, mem_refresh_d;
    logic          mem_wren_q, mem_wren_d;
    logic [13:0]   mem_address_q, mem_address_d;
    logic [63:0]   mem_wdata_q, mem_wdata_d;
    logic [63:0]   p1_data_q, p1_data_d;
    logic [63:0]   p2_from_mem_q, p2_from_mem_d;
    logic          p1_ready_q, p1_ready_d;
    logic          p2_ready_q, p2_ready_d;

    // Round-robin port choice; only acted on in IDLE without pending refresh.
    logic grant_p1, grant_p2;
    assign grant_p1 = p1_req && (!p2_req || last_p2_q);
    assign grant_p2 = p2_req && !grant_p1;

    // Refresh timer runs free. Pending is sticky; an expiry on the same edge
    // as the refresh grant keeps it set so that expiry is not lost.
    logic expire, ref_grant;
    always_comb begin
        expire    = (cnt_q == '0);
        ref_grant = (state_q == IDLE) && pend_q;
        cnt_d     = expire ? RELOAD : cnt_q - 1'b1;
        pend_d    = expire | (pend_q & ~ref_grant);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        last_p2_d = last_p2_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = REFRESH;
                end else if (grant_p1) begin
                    state_d   = SERVE_P1;
                    last_p2_d = 1'b0;
                end else if (grant_p2) begin
                    state_d   = SERVE_P2;
                    last_p2_d = 1'b1;
                end
            end
            REFRESH:            if (mem_ready) state_d = IDLE;
            SERVE_P1, SERVE_P2: if (mem_ready) state_d = RESP;
            RESP:               state_d = IDLE;
            default:            state_d = IDLE;
        endcase
    end

    // Output / datapath next values. Everything holds while a transaction
    // is outstanding so requester input changes never leak downstream.
    always_comb begin
        mem_req_d     = mem_req_q;
        mem_refresh_d = mem_refresh_q;
        mem_wren_d    = mem_wren_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        p1_data_d     = p1_data_q;
        p2_from_mem_d = p2_from_mem_q;
        p1_ready_d    = 1'b0;
        p2_ready_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    mem_req_d     = 1'b1;
                    mem_refresh_d = 1'b1;
                    mem_wren_d    = 1'b0;
                end else if (grant_p1) begin
                    mem_req_d     = 1'b1;
                    mem_address_d = p1_address;
                    mem_wren_d    = 1'b0;
                end else if (grant_p2) begin
                    mem_req_d     = 1'b1;
                    mem_address_d = {1'b0, p2_address} + P2_BASE;
                    mem_wren_d    = p2_wren;
                    mem_wdata_d   = p2_to_mem;
                end
            end
            REFRESH, SERVE_P1, SERVE_P2: begin
                if (mem_ready) begin
                    mem_req_d     = 1'b0;
                    mem_refresh_d = 1'b0;
                    mem_wren_d    = 1'b0;
                    // Ready flops set here so the pulse lands in RESP.
                    if (state_q == SERVE_P1) begin
                        p1_data_d  = mem_rdata;
                        p1_ready_d = 1'b1;
                    end
                    if (state_q == SERVE_P2) begin
                        if (!mem_wren_q) p2_from_mem_d = mem_rdata;
                        p2_ready_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= RELOAD;
            pend_q        <= 1'b0;
            last_p2_q     <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_refresh_q <= 1'b0;
            mem_wren_q    <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            p1_data_q     <= '0;
            p2_from_mem_q <= '0;
            p1_ready_q    <= 1'b0;
            p2_ready_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            last_p2_q     <= last_p2_d;
            mem_req_q     <= mem_req_d;
            mem_refresh_q <= mem_refresh_d;
            mem_wren_q    <= mem_wren_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            p1_data_q     <= p1_data_d;
            p2_from_mem_q <= p2_from_mem_d;
            p1_ready_q    <= p1_ready_d;
            p2_ready_q    <= p2_ready_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_refresh = mem_refresh_q;
    assign mem_wren    = mem_wren_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign p1_data     = p1_data_q;
    assign p2_from_mem = p2_from_mem_q;
    assign p1_ready    = p1_ready_q;
    assign p2_ready    = p2_ready_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;
    localparam int RI  = 390;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        p1_req;
    logic [13:0] p1_address;
    logic [63:0] p1_data;
    logic        p1_ready;
    logic        p2_req, p2_wren;
    logic [12:0] p2_address;
    logic [63:0] p2_to_mem, p2_from_mem;
    logic        p2_ready;
    logic        mem_req, mem_refresh, mem_wren;
    logic [13:0] mem_address;
    logic [63:0] mem_wdata, mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.REFRESH_INTERVAL(RI), .P2_BASE(14'h2000)) dut (
        .clk(clk), .reset(reset),
        .p1_req(p1_req), .p1_address(p1_address), .p1_data(p1_data), .p1_ready(p1_ready),
        .p2_req(p2_req), .p2_wren(p2_wren), .p2_address(p2_address), .p2_to_mem(p2_to_mem),
        .p2_from_mem(p2_from_mem), .p2_ready(p2_ready),
        .mem_req(mem_req), .mem_refresh(mem_refresh), .mem_wren(mem_wren),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct packed {
        logic        is_ref;
        logic [13:0] addr;
        logic        wren;
        logic [63:0] wdata;
    } gnt_t;

    gnt_t        glog[$];               // grants seen by the memory model
    logic [63:0] p1_q[$];               // expected p1_data per p1_ready
    logic [63:0] p2_q[$];               // expected p2_from_mem per p2_ready
    logic [63:0] mem_model[logic [13:0]];
    logic [63:0] p2_last;               // what p2_from_mem should currently hold
    int          checks = 0;
    int          failures = 0;
    bit          resp_en = 1'b1;

    function automatic logic [63:0] pat(input logic [13:0] a);
        return {2'b00, a, 16'hBEEF, 2'b00, a, 16'hCAFE};
    endfunction

    function automatic logic [63:0] rd(input logic [13:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return pat(a);
    endfunction

    // SDRAM controller model: answers LAT cycles after seeing mem_req.
    task automatic responder();
        forever begin
            @(negedge clk);
            if (resp_en && reset && mem_req) begin
                gnt_t g;
                g.is_ref = mem_refresh;
                g.addr   = mem_address;
                g.wren   = mem_wren;
                g.wdata  = mem_wdata;
                glog.push_back(g);
                repeat (LAT - 1) @(negedge clk);
                if (!mem_refresh && mem_wren) mem_model[mem_address] = mem_wdata;
                mem_rdata = (mem_refresh || mem_wren) ? 64'hBAD0_BAD0_BAD0_BAD0 : rd(mem_address);
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
    endtask

    // Scoreboard side: every ready pulse must match a queued expectation.
    task automatic ready_watcher();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (reset && p1_ready) begin
                checks++;
                if (p1_q.size() == 0) begin
                    failures++;
                    $display("FAIL p1_ready_unexpected got=1 want=0");
                end else begin
                    e = p1_q.pop_front();
                    if (p1_data !== e) begin
                        failures++;
                        $display("FAIL p1_data got=%h want=%h", p1_data, e);
                    end
                end
            end
            if (reset && p2_ready) begin
                checks++;
                if (p2_q.size() == 0) begin
                    failures++;
                    $display("FAIL p2_ready_unexpected got=1 want=0");
                end else begin
                    e = p2_q.pop_front();
                    if (p2_from_mem !== e) begin
                        failures++;
                        $display("FAIL p2_from_mem got=%h want=%h", p2_from_mem, e);
                    end
                end
            end
        end
    endtask

    task automatic wait_rdy(input bit port2, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (port2 ? p2_ready : p1_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pop_grant(output gnt_t g, output bit ok);
        ok = (glog.size() != 0);
        g  = '0;
        if (ok) g = glog.pop_front();
    endtask

    task automatic p1_read(input logic [13:0] a);
        bit ok;
        p1_q.push_back(rd(a));
        p1_address = a;
        p1_req = 1'b1;
        wait_rdy(1'b0, ok);
        p1_req = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL p1_timeout addr=%h got=no_ready want=ready", a);
        end
    endtask

    task automatic p2_op(input logic wr, input logic [12:0] a, input logic [63:0] wd);
        bit ok;
        if (!wr) p2_last = rd({1'b0, a} + 14'h2000);
        p2_q.push_back(p2_last);
        p2_address = a;
        p2_wren = wr;
        p2_to_mem = wd;
        p2_req = 1'b1;
        wait_rdy(1'b1, ok);
        p2_req = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL p2_timeout addr=%h got=no_ready want=ready", a);
        end
    endtask

    // Counts posedges after a negedge reset release until mem_req rises,
    // noting any nonzero output seen before then.
    task automatic measure_refresh(output int first, output bit nz);
        first = -1;
        nz = 1'b0;
        for (int n = 1; n <= RI + 20; n++) begin
            @(negedge clk);
            if (mem_req) begin
                first = n;
                break;
            end
            if (mem_refresh || mem_wren || mem_address != 0 || mem_wdata != 0 ||
                p1_data != 0 || p2_from_mem != 0 || p1_ready || p2_ready) nz = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        p1_req = 1'b0;
        p2_req = 1'b0;
        repeat (2) @(negedge clk);
        glog.delete();
        p1_q.delete();
        p2_q.delete();
        p2_last = '0;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int first;
        bit nz, saw;
        gnt_t g;
        bit ok;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req || mem_refresh || mem_wren || p1_ready || p2_ready ||
            mem_address != 0 || mem_wdata != 0 || p1_data != 0 || p2_from_mem != 0) begin
            failures++;
            $display("FAIL reset_outputs got=nonzero want=all_zero");
        end
        reset = 1'b1;
        measure_refresh(first, nz);
        checks++;
        if (nz) begin
            failures++;
            $display("FAIL pre_refresh_outputs got=nonzero want=all_zero");
        end
        // counter 389..0 over edges 1..389, pending set at edge 390, grant at 391
        checks++;
        if (first != RI + 1) begin
            failures++;
            $display("FAIL refresh_first_cycle got=%0d want=%0d", first, RI + 1);
        end
        checks++;
        if (mem_refresh !== 1'b1 || mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL refresh_qual got=ref%b/wr%b want=ref1/wr0", mem_refresh, mem_wren);
        end
        saw = 1'b0;
        repeat (LAT + 6) begin
            @(negedge clk);
            if (p1_ready || p2_ready) saw = 1'b1;
        end
        checks++;
        if (saw || mem_req || mem_refresh) begin
            failures++;
            $display("FAIL refresh_done got=rdy%b/req%b want=rdy0/req0", saw, mem_req);
        end
        pop_grant(g, ok);
        checks++;
        if (!ok || !g.is_ref) begin
            failures++;
            $display("FAIL refresh_grant got=ok%b/ref%b want=ok1/ref1", ok, g.is_ref);
        end
    endtask

    task automatic test_p1_read();
        gnt_t g;
        bit ok;
        mem_model[14'h0123] = 64'hDEADBEEF_01234567;
        p1_read(14'h0123);
        @(negedge clk);
        checks++;
        if (p1_ready !== 1'b0) begin
            failures++;
            $display("FAIL p1_ready_pulse_width got=%b want=0", p1_ready);
        end
        pop_grant(g, ok);
        checks++;
        if (!ok || g.is_ref || g.addr !== 14'h0123 || g.wren !== 1'b0) begin
            failures++;
            $display("FAIL p1_grant got=ok%b/ref%b/%h/wr%b want=ok1/ref0/0123/wr0",
                     ok, g.is_ref, g.addr, g.wren);
        end
        checks++;
        if (p1_data !== 64'hDEADBEEF_01234567) begin
            failures++;
            $display("FAIL p1_data_hold got=%h want=DEADBEEF01234567", p1_data);
        end
    endtask

    task automatic test_p2_rw();
        gnt_t g;
        bit ok;
        logic [13:0] ea [4] = '{14'h2040, 14'h2040, 14'h3FFF, 14'h2040};
        logic        ew [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        p2_op(1'b0, 13'h0040, 64'h0);
        p2_op(1'b1, 13'h0040, 64'h1122334455667788);
        p2_op(1'b0, 13'h1FFF, 64'h0);
        p2_op(1'b0, 13'h0040, 64'h0);   // read-back must return the write data
        for (int i = 0; i < 4; i++) begin
            pop_grant(g, ok);
            checks++;
            if (!ok || g.is_ref || g.addr !== ea[i] || g.wren !== ew[i] ||
                (ew[i] && g.wdata !== 64'h1122334455667788)) begin
                failures++;
                $display("FAIL p2_grant%0d got=ok%b/ref%b/%h/wr%b/%h want=ok1/ref0/%h/wr%b",
                         i, ok, g.is_ref, g.addr, g.wren, g.wdata, ea[i], ew[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        gnt_t g;
        bit ok;
        logic [13:0] ea [4] = '{14'h0011, 14'h2021, 14'h0012, 14'h2022};
        do_reset();
        fork
            begin p1_read(14'h0011); p1_read(14'h0012); end
            begin p2_op(1'b0, 13'h0021, 64'h0); p2_op(1'b0, 13'h0022, 64'h0); end
        join
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pop_grant(g, ok);
            checks++;
            if (!ok || g.is_ref || g.addr !== ea[i]) begin
                failures++;
                $display("FAIL rr_order%0d got=ok%b/ref%b/%h want=ok1/ref0/%h",
                         i, ok, g.is_ref, g.addr, ea[i]);
            end
        end
        checks++;
        if (glog.size() != 0 || mem_req) begin
            failures++;
            $display("FAIL rr_extra_grant got=%0d/req%b want=0/req0", glog.size(), mem_req);
        end
    endtask

    task automatic test_refresh_priority();
        gnt_t g;
        bit ok;
        do_reset();
        // p2 granted at edge 385; expiry at edge 390 lands inside it.
        repeat (384) @(negedge clk);
        fork
            p2_op(1'b0, 13'h0030, 64'h0);
            begin @(negedge clk); p1_read(14'h0031); end
        join
        repeat (5) @(negedge clk);
        pop_grant(g, ok);
        checks++;
        if (!ok || g.is_ref || g.addr !== 14'h2030) begin
            failures++;
            $display("FAIL refprio_first got=ok%b/ref%b/%h want=ok1/ref0/2030", ok, g.is_ref, g.addr);
        end
        pop_grant(g, ok);
        checks++;
        if (!ok || !g.is_ref) begin
            failures++;
            $display("FAIL refprio_second got=ok%b/ref%b want=ok1/ref1", ok, g.is_ref);
        end
        pop_grant(g, ok);
        checks++;
        if (!ok || g.is_ref || g.addr !== 14'h0031) begin
            failures++;
            $display("FAIL refprio_third got=ok%b/ref%b/%h want=ok1/ref0/0031", ok, g.is_ref, g.addr);
        end
    endtask

    task automatic test_reset_abort();
        int first;
        bit nz, seen, saw;
        do_reset();
        resp_en = 1'b0;
        p1_address = 14'h0077;
        p1_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL abort_grant got=req0 want=req1");
        end
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || p1_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_async got=req%b/rdy%b want=req0/rdy0", mem_req, p1_ready);
        end
        p1_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        resp_en = 1'b1;
        measure_refresh(first, nz);
        checks++;
        if (nz || first != RI + 1) begin
            failures++;
            $display("FAIL abort_restart got=%0d/nz%b want=%0d/nz0", first, nz, RI + 1);
        end
        saw = 1'b0;
        repeat (LAT + 6) begin
            @(negedge clk);
            if (p1_ready) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL abort_p1_ready got=1 want=0");
        end
    endtask

    initial begin
        reset = 1'b0;
        p1_req = 1'b0; p1_address = '0;
        p2_req = 1'b0; p2_wren = 1'b0; p2_address = '0; p2_to_mem = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        p2_last = '0;
        fork
            responder();
            ready_watcher();
        join_none
        test_reset();
        test_p1_read();
        test_p2_rw();
        test_round_robin();
        test_refresh_priority();
        test_reset_abort();
        checks++;
        if (p1_q.size() != 0 || p2_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d/%0d want=0/0", p1_q.size(), p2_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
